// File: rtl/ysyx_24090013_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_24090013_mem_arbiter
//   Two-requester arbiter in front of the single NPC memory port.
//   m0 = IFU instruction fetch, m1 = LSU load/store.
//   One owner is granted per transaction and keeps the port until its
//   response handshake completes; arbitration takes one registered cycle.
//
// Parameters
//   ADDR_W  address width
//   DATA_W  data width (multiple of 8)
//   RR      1 = round-robin on ties, 0 = fixed priority (m1 wins ties)
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   mX_req_valid / mX_req_ready        request handshake, X = 0/1
//   mX_addr/wen/wdata/wmask            request fields
//   mX_resp_valid / mX_resp_ready      response handshake
//   mX_rdata                           read data (qualified by resp_valid)
//   s_req_valid / s_req_ready          memory request handshake
//   s_addr/wen/wdata/wmask             owner's request fields
//   s_resp_valid / s_resp_ready        memory response handshake
//   s_rdata                            memory read data
// ----------------------------------------------------------------------------
module ysyx_24090013_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RR     = 1
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_wen,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_resp_valid,
  input  logic                m0_resp_ready,
  output logic [DATA_W-1:0]   m0_rdata,

  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_wen,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_resp_valid,
  input  logic                m1_resp_ready,
  output logic [DATA_W-1:0]   m1_rdata,

  output logic                s_req_valid,
  input  logic                s_req_ready,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_wen,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wmask,
  input  logic                s_resp_valid,
  output logic                s_resp_ready,
  input  logic [DATA_W-1:0]   s_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q,  last_d;
  logic   own_resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign own_resp_ready = owner_q ? m1_resp_ready : m0_resp_ready;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    s_req_valid   = 1'b0;
    s_resp_ready  = 1'b0;
    m0_req_ready  = 1'b0;
    m1_req_ready  = 1'b0;
    m0_resp_valid = 1'b0;
    m1_resp_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m0_req_valid && m1_req_valid) begin
          // Tie: round-robin favours whoever was not served last.
          owner_d = (RR != 0) ? ~last_q : 1'b1;
          state_d = REQ;
        end else if (m0_req_valid) begin
          owner_d = 1'b0;
          state_d = REQ;
        end else if (m1_req_valid) begin
          owner_d = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // Valid comes from the state so a master dropping valid early
        // cannot tear down an in-flight request.
        s_req_valid  = 1'b1;
        m0_req_ready = ~owner_q & s_req_ready;
        m1_req_ready =  owner_q & s_req_ready;
        if (s_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        s_resp_ready  = own_resp_ready;
        m0_resp_valid = ~owner_q & s_resp_valid;
        m1_resp_valid =  owner_q & s_resp_valid;
        if (s_resp_valid && own_resp_ready) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_addr   = owner_q ? m1_addr  : m0_addr;
  assign s_wen    = owner_q ? m1_wen   : m0_wen;
  assign s_wdata  = owner_q ? m1_wdata : m0_wdata;
  assign s_wmask  = owner_q ? m1_wmask : m0_wmask;

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_ysyx_24090013_mem_arbiter.sv
module tb_ysyx_24090013_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rand_on;

  // Directed-phase drivers
  logic        d_valid[2], d_wen[2], d_rready[2];
  logic [31:0] d_addr[2], d_wdata[2];
  logic [3:0]  d_wmask[2];
  logic        d_s_req_ready, d_s_resp_valid;
  logic [31:0] d_s_rdata;

  // Random-phase drivers
  logic        r_valid[2], r_wen[2], r_rready[2];
  logic [31:0] r_addr[2], r_wdata[2];
  logic [3:0]  r_wmask[2];
  logic        r_s_req_ready, r_s_resp_valid;
  logic [31:0] r_s_rdata;

  // DUT-facing signals
  logic        m_valid[2], m_wen[2], m_rready[2];
  logic [31:0] m_addr[2], m_wdata[2];
  logic [3:0]  m_wmask[2];
  logic        m_ready[2], m_rvalid[2];
  logic [31:0] m_rdata[2];
  logic        s_req_valid, s_req_ready, s_wen, s_resp_valid, s_resp_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;

  for (genvar g = 0; g < 2; g++) begin : g_mux
    assign m_valid[g]  = rand_on ? r_valid[g]  : d_valid[g];
    assign m_wen[g]    = rand_on ? r_wen[g]    : d_wen[g];
    assign m_rready[g] = rand_on ? r_rready[g] : d_rready[g];
    assign m_addr[g]   = rand_on ? r_addr[g]   : d_addr[g];
    assign m_wdata[g]  = rand_on ? r_wdata[g]  : d_wdata[g];
    assign m_wmask[g]  = rand_on ? r_wmask[g]  : d_wmask[g];
  end
  assign s_req_ready  = rand_on ? r_s_req_ready  : d_s_req_ready;
  assign s_resp_valid = rand_on ? r_s_resp_valid : d_s_resp_valid;
  assign s_rdata      = rand_on ? r_s_rdata      : d_s_rdata;

  ysyx_24090013_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m_valid[0]), .m0_req_ready(m_ready[0]), .m0_addr(m_addr[0]),
    .m0_wen(m_wen[0]), .m0_wdata(m_wdata[0]), .m0_wmask(m_wmask[0]),
    .m0_resp_valid(m_rvalid[0]), .m0_resp_ready(m_rready[0]), .m0_rdata(m_rdata[0]),
    .m1_req_valid(m_valid[1]), .m1_req_ready(m_ready[1]), .m1_addr(m_addr[1]),
    .m1_wen(m_wen[1]), .m1_wdata(m_wdata[1]), .m1_wmask(m_wmask[1]),
    .m1_resp_valid(m_rvalid[1]), .m1_resp_ready(m_rready[1]), .m1_rdata(m_rdata[1]),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
    .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_rdata(s_rdata)
  );

  // Fixed-priority instance: both masters always requesting, memory always ready.
  logic        fp_m0_req_ready, fp_m1_req_ready, fp_m0_resp_valid, fp_m1_resp_valid;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic        fp_s_req_valid, fp_s_wen, fp_s_resp_ready;
  logic [3:0]  fp_s_wmask;

  ysyx_24090013_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(1'b1), .m0_req_ready(fp_m0_req_ready), .m0_addr(32'h100),
    .m0_wen(1'b0), .m0_wdata(32'h0), .m0_wmask(4'h0),
    .m0_resp_valid(fp_m0_resp_valid), .m0_resp_ready(1'b1), .m0_rdata(fp_m0_rdata),
    .m1_req_valid(1'b1), .m1_req_ready(fp_m1_req_ready), .m1_addr(32'h200),
    .m1_wen(1'b0), .m1_wdata(32'h0), .m1_wmask(4'h0),
    .m1_resp_valid(fp_m1_resp_valid), .m1_resp_ready(1'b1), .m1_rdata(fp_m1_rdata),
    .s_req_valid(fp_s_req_valid), .s_req_ready(1'b1), .s_addr(fp_s_addr),
    .s_wen(fp_s_wen), .s_wdata(fp_s_wdata), .s_wmask(fp_s_wmask),
    .s_resp_valid(1'b1), .s_resp_ready(fp_s_resp_ready), .s_rdata(32'h0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not expected/absent at %0t", name, $time);
  endtask

  // ---------------- transaction-level reference model + scoreboard ----------
  typedef struct {
    bit          own;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  req_t exp_q[$];
  bit   own_q[$];
  bit   busy, last, cur;
  logic req_fire, resp_fire;
  int   fp_checks = 0;

  initial begin
    req_t e;
    bit   w, o;
    busy = 1'b0; last = 1'b1; cur = 1'b0; req_fire = 1'b0; resp_fire = 1'b0;
    forever begin
      @(negedge clk);
      req_fire  = s_req_valid && s_req_ready;
      resp_fire = s_resp_valid && s_resp_ready;
      if (!rst_n) begin
        busy = 1'b0; last = 1'b1;
        exp_q.delete(); own_q.delete();
        continue;
      end
      if (!rand_on) continue;

      // Model: one transaction at a time; ties go to whoever was not served last.
      if (!busy) begin
        if (m_valid[0] || m_valid[1]) begin
          w = (m_valid[0] && m_valid[1]) ? ~last : m_valid[1];
          e.own = w; e.addr = m_addr[w]; e.wen = m_wen[w];
          e.wdata = m_wdata[w]; e.wmask = m_wmask[w];
          exp_q.push_back(e);
          busy = 1'b1; cur = w;
        end
      end else if (m_rvalid[cur] && m_rready[cur]) begin
        last = cur; busy = 1'b0;
      end

      if (req_fire) begin
        if (exp_q.size() == 0) fail("req_unexpected");
        else begin
          e = exp_q.pop_front();
          check("req_addr", 64'(s_addr), 64'(e.addr));
          check("req_fields", 64'({s_wen, s_wmask, s_wdata}), 64'({e.wen, e.wmask, e.wdata}));
          check("req_ready_owner", 64'({m_ready[1], m_ready[0]}), e.own ? 64'd2 : 64'd1);
          own_q.push_back(e.own);
        end
      end

      for (int i = 0; i < 2; i++) begin
        if (m_rvalid[i] && m_rready[i]) begin
          if (own_q.size() == 0) fail("resp_unexpected");
          else begin
            o = own_q.pop_front();
            check("resp_owner", 64'(i), 64'(o));
            check("resp_rdata", 64'(m_rdata[i]), 64'(r_s_rdata));
          end
        end
      end

      if (fp_s_req_valid && fp_checks < 20) begin
        check("fp_grant_m1", 64'(fp_s_addr), 64'h200);
        check("fp_m0_ready", 64'(fp_m0_req_ready), 64'd0);
        fp_checks++;
      end
    end
  end

  // ---------------- random memory slave + response-ready driver -------------
  initial begin
    bit          pend;
    int unsigned dly;
    pend = 1'b0; dly = 0;
    r_s_req_ready = 1'b0; r_s_resp_valid = 1'b0; r_s_rdata = '0;
    r_rready[0] = 1'b0; r_rready[1] = 1'b0;
    forever begin
      @(posedge clk); #1;
      r_rready[0]   = ($urandom_range(0, 3) != 0);
      r_rready[1]   = ($urandom_range(0, 3) != 0);
      r_s_req_ready = ($urandom_range(0, 2) != 0);
      if (!rst_n || !rand_on) begin
        pend = 1'b0; dly = 0; r_s_resp_valid = 1'b0;
      end else if (r_s_resp_valid) begin
        if (resp_fire) begin
          r_s_resp_valid = 1'b0; pend = 1'b0;
        end
      end else if (pend) begin
        if (dly == 0) begin
          r_s_resp_valid = 1'b1; r_s_rdata = $urandom;
        end else dly--;
      end else if (req_fire) begin
        pend = 1'b1; dly = $urandom_range(0, 2);
      end
    end
  end

  task automatic master(input int id, input int n);
    bit got;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      r_addr[id] = $urandom; r_wen[id] = 1'($urandom_range(0, 1));
      r_wdata[id] = $urandom; r_wmask[id] = 4'($urandom_range(0, 15));
      r_valid[id] = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 400 && !got; k++) begin
        @(negedge clk);
        got = m_ready[id];
      end
      if (!got) fail("master_timeout");
      @(posedge clk); #1;
      r_valid[id] = 1'b0;
    end
  endtask

  task automatic m0_read(input logic [31:0] a, input logic [31:0] dat);
    @(posedge clk); #1;
    d_addr[0] = a; d_wen[0] = 1'b0; d_valid[0] = 1'b1; d_s_req_ready = 1'b1; d_rready[0] = 1'b1;
    @(negedge clk); check("rd_idle_no_sreq", 64'(s_req_valid), 64'd0);
    @(negedge clk); check("rd_sreq", 64'({s_req_valid, s_wen, m_ready[0]}), 64'b101);
    check("rd_saddr", 64'(s_addr), 64'(a));
    @(posedge clk); #1;
    d_valid[0] = 1'b0; d_s_resp_valid = 1'b1; d_s_rdata = dat;
    @(negedge clk); check("rd_resp", 64'({m_rvalid[0], m_rvalid[1], s_resp_ready}), 64'b101);
    check("rd_rdata", 64'(m_rdata[0]), 64'(dat));
    @(posedge clk); #1; d_s_resp_valid = 1'b0;
    @(negedge clk); check("rd_done", 64'({m_rvalid[0], m_rvalid[1]}), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; rand_on = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d_valid[i] = 1'b1; d_wen[i] = 1'b0; d_rready[i] = 1'b1;
      d_wdata[i] = '0; d_wmask[i] = '0;
      r_valid[i] = 1'b0; r_wen[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0; r_wmask[i] = '0;
    end
    d_addr[0] = 32'h1111_1111; d_addr[1] = 32'h2222_2222;
    d_s_req_ready = 1'b1; d_s_resp_valid = 1'b1; d_s_rdata = '0;

    // Reset state with every input trying to provoke a handshake
    #3;
    check("rst_handshake", 64'({s_req_valid, s_resp_ready, m_ready[0], m_ready[1], m_rvalid[0], m_rvalid[1]}), 64'd0);
    check("rst_s_addr", 64'(s_addr), 64'h1111_1111);
    d_valid[0] = 1'b0; d_valid[1] = 1'b0; d_s_resp_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;

    m0_read(32'h8000_0000, 32'hDEAD_BEEF);

    // Spurious response in IDLE
    @(posedge clk); #1 d_s_resp_valid = 1'b1;
    @(negedge clk); check("spur_no_resp", 64'({m_rvalid[0], m_rvalid[1], s_resp_ready}), 64'd0);
    @(posedge clk); #1 d_s_resp_valid = 1'b0;

    // Response stall
    d_addr[0] = 32'h300; d_valid[0] = 1'b1; d_rready[0] = 1'b0; d_s_req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    d_valid[0] = 1'b0; d_s_resp_valid = 1'b1; d_s_rdata = 32'hCAFE_0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_sready", 64'(s_resp_ready), 64'd0);
      check("stall_rvalid", 64'(m_rvalid[0]), 64'd1);
      @(posedge clk); #1;
    end
    d_rready[0] = 1'b1;
    @(negedge clk); check("stall_done_hs", 64'({s_resp_ready, m_rvalid[0]}), 64'b11);
    @(posedge clk); #1 d_s_resp_valid = 1'b0;
    @(negedge clk); check("stall_idle", 64'(m_rvalid[0]), 64'd0);

    // m1 write with request stall and a competing m0 request mid-wait
    @(posedge clk); #1;
    d_s_req_ready = 1'b0; d_valid[1] = 1'b1; d_addr[1] = 32'h10; d_wen[1] = 1'b1;
    d_wdata[1] = 32'h1234_5678; d_wmask[1] = 4'hF; d_rready[1] = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        d_valid[0] = 1'b1; d_addr[0] = 32'h400;
      end
      @(negedge clk);
      check("wstall_addr", 64'(s_addr), 64'h10);
      check("wstall_fields", 64'({s_req_valid, s_wen, s_wmask, s_wdata}), 64'({1'b1, 1'b1, 4'hF, 32'h1234_5678}));
      check("wstall_no_ready", 64'({m_ready[1], m_ready[0]}), 64'd0);
      @(posedge clk); #1;
    end
    d_s_req_ready = 1'b1;
    @(negedge clk); check("wstall_accept", 64'({m_ready[1], m_ready[0]}), 64'b10);
    @(posedge clk); #1;
    d_valid[1] = 1'b0; d_valid[0] = 1'b0; d_s_resp_valid = 1'b1; d_s_rdata = 32'h55AA_55AA;
    @(negedge clk); check("wr_resp", 64'({m_rvalid[1], m_rvalid[0]}), 64'b10);
    @(posedge clk); #1 d_s_resp_valid = 1'b0; d_wen[1] = 1'b0;

    // Asynchronous reset while in RESP
    d_addr[0] = 32'h500; d_valid[0] = 1'b1; d_rready[0] = 1'b0; d_s_req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    d_valid[0] = 1'b0; d_s_resp_valid = 1'b1;
    @(negedge clk); check("pre_rst_rvalid", 64'(m_rvalid[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("async_rst_outputs", 64'({s_req_valid, s_resp_ready, m_ready[0], m_ready[1], m_rvalid[0], m_rvalid[1]}), 64'd0);
    d_rready[0] = 1'b1;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk); check("post_rst_no_resp", 64'({m_rvalid[0], s_resp_ready, s_req_valid}), 64'd0);
    @(posedge clk); #1 d_s_resp_valid = 1'b0;
    m0_read(32'h8000_0004, 32'h0BAD_F00D);

    // Randomized phase against the transaction-level model
    @(posedge clk); #1 rst_n = 1'b0; rand_on = 1'b1;
    @(posedge clk); #2 rst_n = 1'b1;
    fork
      master(0, 40);
      master(1, 40);
    join
    for (int k = 0; k < 200 && (busy || exp_q.size() != 0 || own_q.size() != 0); k++) @(negedge clk);
    check("drain_empty", 64'({busy, exp_q.size() != 0, own_q.size() != 0}), 64'd0);
    check("fp_grants_seen", 64'(fp_checks >= 10), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
